// File: rtl/floor_request_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : floor_request_scheduler
// Purpose  : Conditions raw floor-call buttons and latches them as pending
//            requests. Dispatches one target floor at a time to the car
//            controller, using SCAN ordering.
//
// Ports    : clk          - system clock; all state updates on the rising edge
//            rst_n        - asynchronous active-low reset
//            btn_in[7:0]  - raw call buttons, active-high, asynchronous;
//                           bit i = floor i+1
//            cur_floor    - one-hot current car floor from the car controller
//            arrived      - one-cycle pulse; the car completed its stop at target
//            target       - one-hot dispatched floor; 0 when idle
//            target_valid - target is meaningful and held stable
//            pending      - outstanding call requests
//            dir_up       - current scan direction (1 = up)
//
// Build option: FLOOR_DEBOUNCE_EN
//            defined   - each synchronized button passes through a counter
//                        debouncer of DEBOUNCE_CYCLES stable cycles.
//            undefined - the debouncers are removed, and the synchronizer
//                        output feeds the edge detector directly.
//
// Revision : 1.0 - initial release
// ============================================================================
module floor_request_scheduler #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] btn_in,
    input  logic [7:0] cur_floor,
    input  logic       arrived,
    output logic [7:0] target,
    output logic       target_valid,
    output logic [7:0] pending,
    output logic       dir_up
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_sync1;
    logic [7:0] r_sync2;
    logic [7:0] w_level;
    logic [7:0] r_level_d;
    logic [7:0] w_rise;
    logic [7:0] r_pending;
    logic [7:0] w_pending_nxt;
    logic [7:0] r_target;
    logic [7:0] w_target_nxt;
    logic       r_dir_up;
    logic       w_dir_up_nxt;
    logic [7:0] w_clear;
    logic [2:0] w_cur_idx;
    logic [2:0] w_up_idx;
    logic [2:0] w_dn_idx;
    logic       w_up_found;
    logic       w_dn_found;

    // Out-of-range parameter values produce no logic here; this block exists
    // so the parameter is referenced in every build variant.
    if ((DEBOUNCE_CYCLES < 2) || (DEBOUNCE_CYCLES > 255)) begin : g_debounce_range_violation
    end

    // ------------------------------------------------------------------
    // Two-flop synchronizer for the asynchronous buttons
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 8'h00;
            r_sync2 <= 8'h00;
        end else begin
            r_sync1 <= btn_in;
            r_sync2 <= r_sync1;
        end
    end

`ifdef FLOOR_DEBOUNCE_EN
    localparam logic [7:0] C_CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    for (genvar gi = 0; gi < 8; gi++) begin : g_debounce
        logic       r_deb;
        logic [7:0] r_cnt;

        // The counter runs only while the synchronized level disagrees with
        // the accepted level. The level flips on the cycle that would make
        // the count equal DEBOUNCE_CYCLES.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_deb <= 1'b0;
                r_cnt <= 8'h00;
            end else if (r_sync2[gi] == r_deb) begin
                r_cnt <= 8'h00;
            end else if (r_cnt == C_CNT_LAST) begin
                r_deb <= r_sync2[gi];
                r_cnt <= 8'h00;
            end else begin
                r_cnt <= r_cnt + 8'h01;
            end
        end

        assign w_level[gi] = r_deb;
    end
`else
    assign w_level = r_sync2;
`endif

    // Only a press registers a call. A release is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level_d <= 8'h00;
        end else begin
            r_level_d <= w_level;
        end
    end

    assign w_rise = w_level & ~r_level_d;

    // ------------------------------------------------------------------
    // Floor index helpers
    // ------------------------------------------------------------------
    // Lowest set bit wins. An all-zero cur_floor falls back to index 0.
    always_comb begin
        w_cur_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (cur_floor[i]) begin
                w_cur_idx = 3'(i);
            end
        end
    end

    // Nearest pending floor above (lowest index) and below (highest index)
    // the current floor.
    always_comb begin
        w_up_idx   = 3'd0;
        w_up_found = 1'b0;
        w_dn_idx   = 3'd0;
        w_dn_found = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (r_pending[i] && (3'(i) > w_cur_idx)) begin
                w_up_idx   = 3'(i);
                w_up_found = 1'b1;
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (r_pending[i] && (3'(i) < w_cur_idx)) begin
                w_dn_idx   = 3'(i);
                w_dn_found = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Dispatch FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_target_nxt = r_target;
        w_dir_up_nxt = r_dir_up;
        w_clear      = 8'h00;
        case (r_state)
            ST_IDLE: begin
                if (|r_pending) begin
                    w_state_nxt = ST_BUSY;
                    if (r_pending[w_cur_idx]) begin
                        w_target_nxt = 8'h01 << w_cur_idx;
                    end else if (r_dir_up && w_up_found) begin
                        w_target_nxt = 8'h01 << w_up_idx;
                    end else if (!r_dir_up && w_dn_found) begin
                        w_target_nxt = 8'h01 << w_dn_idx;
                    end else begin
                        // Nothing ahead: reverse. Because pending is nonzero
                        // and the current floor is not pending, a call must
                        // exist on the other side.
                        w_dir_up_nxt = ~r_dir_up;
                        w_target_nxt = r_dir_up ? (8'h01 << w_dn_idx)
                                                : (8'h01 << w_up_idx);
                    end
                end
            end
            ST_BUSY: begin
                if (arrived) begin
                    w_clear     = r_target;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // If a new press lands in the same cycle that an arrival clears the bit,
    // the new press wins.
    assign w_pending_nxt = (r_pending & ~w_clear) | w_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 8'h00;
            r_target  <= 8'h00;
            r_dir_up  <= 1'b1;
        end else begin
            r_pending <= w_pending_nxt;
            r_target  <= w_target_nxt;
            r_dir_up  <= w_dir_up_nxt;
        end
    end

    assign target_valid = (r_state == ST_BUSY);
    assign target       = (r_state == ST_BUSY) ? r_target : 8'h00;
    assign pending      = r_pending;
    assign dir_up       = r_dir_up;

endmodule
`default_nettype wire
